// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared types and constants for the 3-way Wishbone round-robin arbiter
package wshb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, PARK, LOCKOUT} state_t;
  typedef logic [1:0] owner_t;
  localparam owner_t VGA  = 2'd0;
  localparam owner_t MIRE = 2'd1;
  localparam owner_t AUX  = 2'd2;
  function automatic owner_t oh2idx(input logic [2:0] oh);
    return oh[2] ? AUX : oh[1] ? MIRE : VGA;
  endfunction
  function automatic logic [2:0] idx2oh(input owner_t i);
    return 3'b001 << i;
  endfunction
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone B4 bundle; master drives cyc/stb/adr/we/sel/cti/bte/dat_ms, slave returns ack/err/rty/dat_sm
interface wshb_if #(parameter int DW = 32, parameter int AW = 32);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_ms;
  logic [DW-1:0] dat_sm;
  logic [DW/8-1:0] sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;
  modport master(output cyc, stb, we, adr, dat_ms, sel, cti, bte, input ack, err, rty, dat_sm);
  modport slave(input cyc, stb, we, adr, dat_ms, sel, cti, bte, output ack, err, rty, dat_sm);
endinterface

// File: rtl/rr_pick3.sv
// rr_pick3: combinational 3-way picker, urgent vga first, else round-robin after ptr
//   req: cyc of {aux, mire, vga}; ptr: last owner; urgent: vga priority; gnt: one-hot pick
module rr_pick3
  import wshb_arb_pkg::*;
(
  input  logic [2:0] req,
  input  owner_t     ptr,
  input  logic       urgent,
  output logic [2:0] gnt
);
  always_comb
    gnt = (urgent && req[0]) ? 3'b001 :
          (ptr == VGA)  ? (req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000) :
          (ptr == MIRE) ? (req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000) :
                          (req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000);
endmodule

// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: shares one SDRAM Wishbone port between vga, mire and aux with timeout
//   clk/rst_n: clock, async active-low reset; wshb_ifs_*: requesters; wshb_ifm_sdram: shared port
//   vga_urgent: vga priority in IDLE; grant: one-hot owner; timeout_cnt: saturating forced-release count
module wshb_rr_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  wshb_if.slave      wshb_ifs_vga,
  wshb_if.slave      wshb_ifs_mire,
  wshb_if.slave      wshb_ifs_aux,
  wshb_if.master     wshb_ifm_sdram,
  input  logic       vga_urgent,
  output logic [2:0] grant,
  output logic [7:0] timeout_cnt
);
  state_t           state_q, state_d;
  owner_t           owner_q, owner_d, last_q, last_d;
  logic [2:0]       grant_q, grant_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             in_grant, own_m, own_a, own_cyc, own_stb, tmo, v_sel, m_sel, a_sel;
  rr_pick3 u_pick (
    .req    ({wshb_ifs_aux.cyc, wshb_ifs_mire.cyc, wshb_ifs_vga.cyc}),
    .ptr    (last_q),
    .urgent (vga_urgent),
    .gnt    (pick)
  );
  assign in_grant = state_q == GRANT;
  assign own_m    = owner_q == MIRE;
  assign own_a    = owner_q == AUX;
  assign own_cyc  = own_m ? wshb_ifs_mire.cyc : own_a ? wshb_ifs_aux.cyc : wshb_ifs_vga.cyc;
  assign own_stb  = own_m ? wshb_ifs_mire.stb : own_a ? wshb_ifs_aux.stb : wshb_ifs_vga.stb;
  // A release on the last allowed cycle wins over the timeout
  assign tmo      = in_grant && own_cyc && cnt_q == CNT_W'(TIMEOUT - 1);
  assign wshb_ifm_sdram.cyc    = in_grant & own_cyc;
  assign wshb_ifm_sdram.stb    = in_grant & own_stb;
  assign wshb_ifm_sdram.adr    = own_m ? wshb_ifs_mire.adr    : own_a ? wshb_ifs_aux.adr    : wshb_ifs_vga.adr;
  assign wshb_ifm_sdram.we     = own_m ? wshb_ifs_mire.we     : own_a ? wshb_ifs_aux.we     : wshb_ifs_vga.we;
  assign wshb_ifm_sdram.sel    = own_m ? wshb_ifs_mire.sel    : own_a ? wshb_ifs_aux.sel    : wshb_ifs_vga.sel;
  assign wshb_ifm_sdram.cti    = own_m ? wshb_ifs_mire.cti    : own_a ? wshb_ifs_aux.cti    : wshb_ifs_vga.cti;
  assign wshb_ifm_sdram.bte    = own_m ? wshb_ifs_mire.bte    : own_a ? wshb_ifs_aux.bte    : wshb_ifs_vga.bte;
  assign wshb_ifm_sdram.dat_ms = own_m ? wshb_ifs_mire.dat_ms : own_a ? wshb_ifs_aux.dat_ms : wshb_ifs_vga.dat_ms;
  assign v_sel = in_grant && owner_q == VGA;
  assign m_sel = in_grant && own_m;
  assign a_sel = in_grant && own_a;
  assign wshb_ifs_vga.ack  = v_sel & wshb_ifm_sdram.ack & ~tmo;
  assign wshb_ifs_vga.err  = v_sel & (wshb_ifm_sdram.err | tmo);
  assign wshb_ifs_vga.rty  = v_sel & wshb_ifm_sdram.rty;
  assign wshb_ifs_mire.ack = m_sel & wshb_ifm_sdram.ack & ~tmo;
  assign wshb_ifs_mire.err = m_sel & (wshb_ifm_sdram.err | tmo);
  assign wshb_ifs_mire.rty = m_sel & wshb_ifm_sdram.rty;
  assign wshb_ifs_aux.ack  = a_sel & wshb_ifm_sdram.ack & ~tmo;
  assign wshb_ifs_aux.err  = a_sel & (wshb_ifm_sdram.err | tmo);
  assign wshb_ifs_aux.rty  = a_sel & wshb_ifm_sdram.rty;
  assign wshb_ifs_vga.dat_sm  = wshb_ifm_sdram.dat_sm;
  assign wshb_ifs_mire.dat_sm = wshb_ifm_sdram.dat_sm;
  assign wshb_ifs_aux.dat_sm  = wshb_ifm_sdram.dat_sm;
  assign grant       = grant_q;
  assign timeout_cnt = tcnt_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE:
        if (|pick) begin
          state_d = GRANT;
          owner_d = oh2idx(pick);
          cnt_d   = '0;
        end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (!own_cyc) begin
          state_d = PARK;
          last_d  = owner_q;
        end else if (tmo) begin
          state_d = LOCKOUT;
          tcnt_d  = tcnt_q + {7'd0, ~&tcnt_q};
        end
      end
      LOCKOUT:
        if (!own_cyc) begin
          state_d = PARK;
          last_d  = owner_q;
        end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == GRANT || state_d == LOCKOUT) ? idx2oh(owner_d) : 3'b000;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= VGA;
      last_q  <= AUX;
      grant_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb_wshb_rr_arbiter: directed scoreboard bench for wshb_rr_arbiter (TIMEOUT=16)
module tb_wshb_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vga_urgent = 1'b0;
  logic [2:0] grant;
  logic [7:0] timeout_cnt;
  int         checks = 0;
  int         passed = 0;
  logic [2:0] exp_q[$];
  int         ack_n[3];
  wshb_if vga_if();
  wshb_if mire_if();
  wshb_if aux_if();
  wshb_if sdram_if();
  always #5 clk = ~clk;
  assign sdram_if.ack    = sdram_if.cyc & sdram_if.stb;
  assign sdram_if.err    = 1'b0;
  assign sdram_if.rty    = 1'b0;
  assign sdram_if.dat_sm = 32'hCAFE_F00D;
  wshb_rr_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wshb_ifs_vga   (vga_if),
    .wshb_ifs_mire  (mire_if),
    .wshb_ifs_aux   (aux_if),
    .wshb_ifm_sdram (sdram_if),
    .vga_urgent     (vga_urgent),
    .grant          (grant),
    .timeout_cnt    (timeout_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic [2:0] c);
    vga_if.cyc  = c[0];
    vga_if.stb  = c[0];
    mire_if.cyc = c[1];
    mire_if.stb = c[1];
    aux_if.cyc  = c[2];
    aux_if.stb  = c[2];
  endtask
  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == 3'b000 && n < 50) begin
      tick;
      n++;
    end
    chk(tag, grant, exp_q.pop_front());
  endtask
  task automatic init_bus;
    set_req(3'b000);
    vga_if.adr = 32'h1000_0000;  vga_if.we = 1'b0;  vga_if.sel = 4'hF;  vga_if.cti = 3'd0;  vga_if.bte = 2'd0;  vga_if.dat_ms = 32'h1111_1111;
    mire_if.adr = 32'h2000_0000; mire_if.we = 1'b1; mire_if.sel = 4'h3; mire_if.cti = 3'd2; mire_if.bte = 2'd1; mire_if.dat_ms = 32'h2222_2222;
    aux_if.adr = 32'h3000_0000;  aux_if.we = 1'b1;  aux_if.sel = 4'hC;  aux_if.cti = 3'd7; aux_if.bte = 2'd3;  aux_if.dat_ms = 32'h3333_3333;
  endtask
  initial begin
    logic [2:0] prev, a, c;
    int ng, gap;
    init_bus;
    tick;
    tick;
    chk("rst_grant", grant, 3'b000);
    chk("rst_tcnt", timeout_cnt, 8'd0);
    chk("rst_sdram_cyc", sdram_if.cyc, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick;
    // single mire transaction
    set_req(3'b010);
    exp_q.push_back(3'b010);
    tick;
    chk("mire_grant", grant, exp_q.pop_front());
    chk("mire_sdram_cyc", sdram_if.cyc, 1'b1);
    chk("mire_sdram_adr", sdram_if.adr, 32'h2000_0000);
    chk("mire_sdram_dat", sdram_if.dat_ms, 32'h2222_2222);
    chk("mire_sdram_we", sdram_if.we, 1'b1);
    chk("mire_ack", mire_if.ack, 1'b1);
    chk("mire_vga_ack", vga_if.ack, 1'b0);
    chk("mire_bcast", vga_if.dat_sm, 32'hCAFE_F00D);
    repeat (13) tick;
    chk("mire_hold", grant, 3'b010);
    set_req(3'b000);
    #1;
    chk("mire_drop_cyc", sdram_if.cyc, 1'b0);
    tick;
    chk("mire_park_grant", grant, 3'b000);
    chk("mire_park_ack", mire_if.ack, 1'b0);
    set_req(3'b001);
    exp_q.push_back(3'b001);
    tick;
    chk("park_one_cycle", grant, 3'b000);
    tick;
    chk("idle_then_grant", grant, exp_q.pop_front());
    set_req(3'b000);
    repeat (3) tick;
    // round-robin with all three requesting, each releasing after 4 acks
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    ack_n = '{0, 0, 0};
    ng = 0;
    gap = 0;
    prev = 3'b000;
    set_req(3'b111);
    for (int cy = 0; cy < 200 && ng < 4; cy++) begin
      tick;
      if (grant != 3'b000 && prev == 3'b000) begin
        chk("rr_order", grant, exp_q.pop_front());
        if (ng > 0) chk("rr_gap_park_idle", gap, 2);
        ng++;
        gap = 0;
      end
      if (grant == 3'b000) gap++;
      prev = grant;
      a = {aux_if.ack, mire_if.ack, vga_if.ack};
      c = 3'b111;
      for (int i = 0; i < 3; i++)
        if (a[i]) begin
          ack_n[i]++;
          if (ack_n[i] == 4) begin
            ack_n[i] = 0;
            c[i] = 1'b0;
          end
        end
      set_req(c);
    end
    chk("rr_grants", ng, 4);
    set_req(3'b000);
    repeat (3) tick;
    // urgent vga after vga was last owner
    vga_urgent = 1'b1;
    set_req(3'b111);
    exp_q.push_back(3'b001);
    tick;
    chk("urgent_vga", grant, exp_q.pop_front());
    set_req(3'b110);
    tick;
    vga_urgent = 1'b0;
    set_req(3'b111);
    exp_q.push_back(3'b010);
    wait_grant("rr_mire_after_vga");
    vga_urgent = 1'b1;
    repeat (4) tick;
    chk("no_preempt", grant, 3'b010);
    exp_q.push_back(3'b001);
    set_req(3'b101);
    tick;
    wait_grant("urgent_after_mire");
    vga_urgent = 1'b0;
    set_req(3'b000);
    repeat (3) tick;
    // non-owner toggling during a vga grant
    set_req(3'b001);
    exp_q.push_back(3'b001);
    wait_grant("iso_vga_grant");
    for (int i = 0; i < 8; i++) begin
      mire_if.cyc = i[0];
      mire_if.stb = ~i[1];
      aux_if.cyc  = ~i[0];
      aux_if.stb  = i[2];
      mire_if.adr = $urandom;
      aux_if.adr  = $urandom;
      #1;
      chk("iso_sdram_adr", sdram_if.adr, 32'h1000_0000);
      chk("iso_sdram_cyc", {sdram_if.cyc, sdram_if.stb}, 2'b11);
      chk("iso_others", {mire_if.ack, mire_if.err, mire_if.rty, aux_if.ack, aux_if.err, aux_if.rty}, 6'd0);
      tick;
    end
    mire_if.adr = 32'h2000_0000;
    aux_if.adr  = 32'h3000_0000;
    set_req(3'b000);
    repeat (3) tick;
    // reset mid-burst on vga with mire pending
    set_req(3'b001);
    exp_q.push_back(3'b001);
    wait_grant("rst_vga_grant");
    set_req(3'b011);
    tick;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", sdram_if.cyc, 1'b0);
    chk("rst_mid_grant", grant, 3'b000);
    chk("rst_mid_ack", {vga_if.ack, vga_if.err}, 2'b00);
    set_req(3'b010);
    tick;
    chk("rst_held_grant", grant, 3'b000);
    rst_n = 1'b1;
    exp_q.push_back(3'b010);
    tick;
    chk("rst_mire_next_edge", grant, exp_q.pop_front());
    set_req(3'b000);
    repeat (3) tick;
    // timeout on aux
    set_req(3'b100);
    exp_q.push_back(3'b100);
    tick;
    chk("tmo_aux_grant", grant, exp_q.pop_front());
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick;
      chk("tmo_ack", aux_if.ack, k < 16);
      chk("tmo_err", aux_if.err, k == 16);
    end
    tick;
    chk("tmo_lock_cyc", sdram_if.cyc, 1'b0);
    chk("tmo_lock_grant", grant, 3'b100);
    chk("tmo_cnt1", timeout_cnt, 8'd1);
    chk("tmo_err_single", aux_if.err, 1'b0);
    repeat (3) tick;
    chk("tmo_lock_hold", sdram_if.cyc, 1'b0);
    set_req(3'b000);
    tick;
    chk("tmo_park", grant, 3'b000);
    tick;
    // release on the last allowed cycle is a normal release
    set_req(3'b100);
    exp_q.push_back(3'b100);
    tick;
    chk("edge_aux_grant", grant, exp_q.pop_front());
    repeat (15) tick;
    set_req(3'b000);
    #1;
    chk("edge_no_err", aux_if.err, 1'b0);
    tick;
    chk("edge_released", grant, 3'b000);
    chk("edge_no_count", timeout_cnt, 8'd1);
    tick;
    // saturate the timeout counter
    for (int n = 0; n < 299; n++) begin
      set_req(3'b100);
      repeat (17) tick;
      set_req(3'b000);
      repeat (2) tick;
    end
    chk("tmo_saturate", timeout_cnt, 8'd255);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
